// File: rtl/sdr_naf_encoder.sv
// Multi-channel NAF serialiser: converts NCH unsigned words to non-adjacent-form digits
// LSB-first, then emits them MSB-first with a per-channel nonzero-term budget.
module sdr_naf_lane #(
    parameter int W  = 8,
    parameter int BW = 4,
    parameter int IW = $clog2(W+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accept_i,
    input  logic [W-1:0]  word_i,
    input  logic          conv_i,
    input  logic [IW-1:0] cnt_i,
    input  logic          beat_load_i,
    input  logic          first_i,
    input  logic [IW-1:0] beat_idx_i,
    input  logic          last_i,
    input  logic          clr_i,
    input  logic [BW-1:0] budget_i,
    output logic          nz_o,
    output logic          sign_o,
    output logic          trunc_o
);
    logic [W:0]    x_q, x_d, dnz_q, dsg_q;
    logic [BW-1:0] used_q;
    logic          tacc_q, nz_q, sign_q, trunc_q;
    logic          d_nz, d_neg, b_nz, b_sg, ok, sup;

    always_comb begin
        d_nz  = x_q[0];
        d_neg = x_q[0] & x_q[1];
        x_d   = x_q >> 1;
        if (d_nz)
            x_d = d_neg ? ((x_q + (W+1)'(1)) >> 1) : ((x_q - (W+1)'(1)) >> 1);
        // The MSB digit is produced on the same edge its beat is loaded, so bypass the store.
        b_nz = first_i ? d_nz  : dnz_q[beat_idx_i];
        b_sg = first_i ? d_neg : dsg_q[beat_idx_i];
        ok   = used_q < budget_i;
        sup  = b_nz & ~ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            dnz_q   <= '0;
            dsg_q   <= '0;
            used_q  <= '0;
            tacc_q  <= 1'b0;
            nz_q    <= 1'b0;
            sign_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            if (accept_i) begin
                x_q    <= {1'b0, word_i};
                used_q <= '0;
                tacc_q <= 1'b0;
            end
            if (conv_i) begin
                x_q               <= x_d;
                dnz_q[cnt_i]      <= d_nz;
                dsg_q[cnt_i]      <= d_neg;
            end
            if (beat_load_i) begin
                nz_q    <= b_nz & ok;
                sign_q  <= b_sg & b_nz & ok;
                if (b_nz && ok) used_q <= used_q + BW'(1);
                tacc_q  <= tacc_q | sup;
                trunc_q <= last_i & (tacc_q | sup);
            end else if (clr_i) begin
                nz_q    <= 1'b0;
                sign_q  <= 1'b0;
                trunc_q <= 1'b0;
            end
        end
    end

    assign nz_o    = nz_q;
    assign sign_o  = sign_q;
    assign trunc_o = trunc_q;
endmodule

module sdr_naf_encoder #(
    parameter int W   = 8,
    parameter int NCH = 4,
    parameter int BW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [NCH*W-1:0] in_data_i,
    input  logic [BW-1:0]    in_budget_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [NCH-1:0]   out_nz_o,
    output logic [NCH-1:0]   out_sign_o,
    output logic             out_last_o,
    output logic [NCH-1:0]   out_trunc_o
);
    localparam int IW = $clog2(W+1);
    localparam logic [IW-1:0] LASTD = IW'(W);

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    state_t        state_q;
    logic [IW-1:0] cnt_q, idx_q, beat_idx;
    logic [BW-1:0] budget_q;
    logic          out_valid_q, out_last_q;
    logic          accept, conv, first, beat_load, last, clr;

    always_comb begin
        accept    = (state_q == IDLE) & in_valid_i;
        conv      = (state_q == CONV);
        first     = conv & (cnt_q == LASTD);
        clr       = (state_q == EMIT) & out_ready_i & (idx_q == '0);
        beat_load = first | ((state_q == EMIT) & out_ready_i & (idx_q != '0));
        beat_idx  = first ? LASTD : idx_q - IW'(1);
        last      = (beat_idx == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            budget_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    budget_q <= in_budget_i;
                    cnt_q    <= '0;
                    state_q  <= CONV;
                end
                CONV: begin
                    cnt_q <= cnt_q + IW'(1);
                    if (cnt_q == LASTD) begin
                        state_q     <= EMIT;
                        idx_q       <= LASTD;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (LASTD == '0);
                    end
                end
                EMIT: if (out_ready_i) begin
                    if (idx_q == '0) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end else begin
                        idx_q      <= idx_q - IW'(1);
                        out_last_q <= (idx_q == IW'(1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        sdr_naf_lane #(.W(W), .BW(BW), .IW(IW)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .accept_i   (accept),
            .word_i     (in_data_i[c*W +: W]),
            .conv_i     (conv),
            .cnt_i      (cnt_q),
            .beat_load_i(beat_load),
            .first_i    (first),
            .beat_idx_i (beat_idx),
            .last_i     (last),
            .clr_i      (clr),
            .budget_i   (budget_q),
            .nz_o       (out_nz_o[c]),
            .sign_o     (out_sign_o[c]),
            .trunc_o    (out_trunc_o[c])
        );
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
endmodule

// File: tb/tb_sdr_naf_encoder.sv
// Bench for sdr_naf_encoder: directed and random transactions against an arithmetic NAF/budget model.
module tb_sdr_naf_encoder;
    localparam int W = 8, NCH = 4, BW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, out_valid, out_ready, out_last;
    logic [NCH*W-1:0] in_data;
    logic [BW-1:0]    in_budget;
    logic [NCH-1:0]   out_nz, out_sign, out_trunc;

    int n_chk = 0;
    int n_fail = 0;

    sdr_naf_encoder #(.W(W), .NCH(NCH), .BW(BW)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_budget_i(in_budget),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_nz_o(out_nz), .out_sign_o(out_sign),
        .out_last_o(out_last), .out_trunc_o(out_trunc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_budget = '0;
        step(); step();
        reset = 1'b0;
        n_chk++;
        if ({in_ready, out_valid, out_nz, out_sign, out_last, out_trunc} !== {1'b1, 1'b0, {(3*NCH+1){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b nz=%b sg=%b last=%b tr=%b, want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, out_nz, out_sign, out_last, out_trunc);
        end
    endtask

    // One transaction: optional stall of stall_len cycles at beat stall_idx, optional reset at abort_idx.
    task automatic run_txn(input logic [NCH*W-1:0] data, input logic [BW-1:0] bud,
                           input int stall_idx, input int stall_len, input int abort_idx, input string nm);
        int dg[NCH][W+1];
        logic [NCH-1:0] etr;
        logic [NCH-1:0] xn, xs, xt, sv_nz, sv_sg, sv_tr;
        logic sv_last;
        int x, used, lat, idx, beats, guard;
        etr = '0;
        for (int c = 0; c < NCH; c++) begin
            x = int'(data[c*W +: W]);
            for (int i = 0; i <= W; i++) begin
                if (x % 2 == 0)      dg[c][i] = 0;
                else if (x % 4 == 1) dg[c][i] = 1;
                else                 dg[c][i] = -1;
                x = (x - dg[c][i]) / 2;
            end
            used = 0;
            for (int i = W; i >= 0; i--) begin
                if (dg[c][i] != 0) begin
                    if (used < int'(bud)) used++;
                    else begin dg[c][i] = 0; etr[c] = 1'b1; end
                end
            end
        end

        guard = 0;
        while (!in_ready && guard < 100) begin step(); guard++; end
        in_valid = 1'b1; in_data = data; in_budget = bud;
        step();
        in_valid = 1'b0; in_data = (NCH*W)'($urandom); in_budget = BW'($urandom);
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s accept_ready_drop: got %b want 0", nm, in_ready);
        end

        lat = 0;
        while (!out_valid && lat < 100) begin step(); lat++; end
        n_chk++;
        if (lat != W + 1) begin
            n_fail++; $display("FAIL %s first_beat_latency: got %0d edges want %0d", nm, lat, W + 1);
        end

        idx = W; beats = 0; guard = 0;
        while (idx >= 0 && guard < 200) begin
            guard++;
            for (int c = 0; c < NCH; c++) begin
                xn[c] = dg[c][idx] != 0;
                xs[c] = dg[c][idx] < 0;
            end
            xt = (idx == 0) ? etr : '0;
            n_chk++;
            if ({out_valid, out_nz, out_sign, out_last, out_trunc} !== {1'b1, xn, xs, idx == 0, xt}) begin
                n_fail++;
                $display("FAIL %s beat_idx%0d: got vld=%b nz=%b sg=%b last=%b tr=%b want vld=1 nz=%b sg=%b last=%b tr=%b",
                         nm, idx, out_valid, out_nz, out_sign, out_last, out_trunc, xn, xs, idx == 0, xt);
            end
            if (idx == abort_idx) begin
                reset = 1'b1; step(); reset = 1'b0;
                n_chk++;
                if ({out_valid, in_ready} !== 2'b01) begin
                    n_fail++; $display("FAIL %s reset_abort: got vld=%b rdy=%b want vld=0 rdy=1", nm, out_valid, in_ready);
                end
                return;
            end
            for (int s = 0; idx == stall_idx && s < stall_len; s++) begin
                sv_nz = out_nz; sv_sg = out_sign; sv_tr = out_trunc; sv_last = out_last;
                out_ready = 1'b0;
                step();
                n_chk++;
                if ({out_valid, in_ready, out_nz, out_sign, out_trunc, out_last} !== {2'b10, sv_nz, sv_sg, sv_tr, sv_last}) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got vld=%b rdy=%b nz=%b sg=%b want vld=1 rdy=0 nz=%b sg=%b",
                             nm, out_valid, in_ready, out_nz, out_sign, sv_nz, sv_sg);
                end
            end
            out_ready = 1'b1;
            step();
            beats++;
            idx--;
            if (idx >= 0 && !out_valid) begin
                n_chk++; n_fail++;
                $display("FAIL %s beat_missing: got vld=0 at idx%0d want 1", nm, idx);
                idx = -1;
            end
        end
        n_chk++;
        if ({out_valid, in_ready} !== 2'b01 || beats != W + 1) begin
            n_fail++;
            $display("FAIL %s txn_end: got vld=%b rdy=%b beats=%0d want vld=0 rdy=1 beats=%0d",
                     nm, out_valid, in_ready, beats, W + 1);
        end
    endtask

    task automatic test_directed();
        run_txn({8'h00, 8'h00, 8'h00, 8'h07}, 4'd3, -1, 0, -1, "ch0_seven");
        run_txn({8'h00, 8'h00, 8'hAB, 8'h00}, 4'd2, -1, 0, -1, "ch1_ab_budget2");
        run_txn({8'hFF, 8'h55, 8'h00, 8'h00}, 4'd3, -1, 0, -1, "ch2_55_ch3_ff");
        run_txn({8'hFF, 8'hFF, 8'hFF, 8'h00}, 4'd0, -1, 0, -1, "budget_zero");
        run_txn({8'hAB, 8'h55, 8'hFF, 8'h07}, 4'd15, -1, 0, -1, "budget_max");
    endtask

    task automatic test_stall();
        run_txn({8'hAB, 8'h55, 8'hFF, 8'h07}, 4'd2, 5, 3, -1, "stall_idx5");
    endtask

    task automatic test_reset_mid();
        run_txn({8'hAB, 8'h55, 8'hFF, 8'h07}, 4'd1, -1, 0, 4, "reset_mid_emit");
        run_txn({8'h3C, 8'hAB, 8'h55, 8'hFF}, 4'd3, -1, 0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 20; t++)
            run_txn((NCH*W)'($urandom), BW'($urandom_range(0, 6)),
                    int'($urandom_range(0, W)), int'($urandom_range(0, 3)), -1, "random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
